// File: rtl/display_pixel_fetcher.sv
// Display timing generator and frame-buffer fetcher feeding the colour palette.
// Stage 0: raster counters. Stage 1: registered frame-buffer read request.
// Stage 2: 4bpp unpack into the palette index. Stage 3: sync/active flags,
// one cycle behind the index so they line up with the palette's registered output.
module display_pixel_fetcher #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 400,
   parameter int H_TOTAL    = 800,
   parameter int V_TOTAL    = 450,
   parameter int H_SYNC_POS = 656,
   parameter int H_SYNC_LEN = 64,
   parameter int V_SYNC_POS = 410,
   parameter int V_SYNC_LEN = 4,
   parameter int ADDR_W     = 17
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              enable_in,
   input  logic              swap_request_in,
   output logic              fb_read_enable_out,
   output logic [ADDR_W-1:0] fb_read_addr_out,
   input  logic [15:0]       fb_read_data_in,
   output logic [3:0]        pixel_index_out,
   output logic              active_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              frame_start_out,
   output logic              displayed_buffer_out
);

   localparam int H_W = $clog2(H_TOTAL + 1);
   localparam int V_W = $clog2(V_TOTAL + 1);

   localparam logic [H_W-1:0] H_ACT        = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_SYNC_BEGIN = H_W'(H_SYNC_POS);
   localparam logic [H_W-1:0] H_SYNC_END   = H_W'(H_SYNC_POS + H_SYNC_LEN);
   localparam logic [V_W-1:0] V_ACT        = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] V_ACT_LAST   = V_W'(V_ACTIVE - 1);
   localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_SYNC_BEGIN = V_W'(V_SYNC_POS);
   localparam logic [V_W-1:0] V_SYNC_END   = V_W'(V_SYNC_POS + V_SYNC_LEN);
   localparam logic [ADDR_W-1:0] BUF_B_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE / 4);

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic frame_start;
   } sync_flags_t;

   logic [H_W-1:0]    h_count;
   logic [V_W-1:0]    v_count;
   logic [ADDR_W-1:0] word_ptr;
   logic [ADDR_W-1:0] buffer_base;
   logic              swap_pending;
   logic              read_q;
   logic [1:0]        phase_1;
   logic [15:0]       word_reg;
   logic              h_wrap;
   logic              frame_wrap;
   logic              vblank_entry;
   logic              fetch_0;
   sync_flags_t       flags_0;
   sync_flags_t       flags_1;
   sync_flags_t       flags_2;

   assign h_wrap       = (h_count == H_LAST);
   assign frame_wrap   = h_wrap && (v_count == V_LAST);
   assign vblank_entry = h_wrap && (v_count == V_ACT_LAST);
   assign flags_0 = '{
      active:      (h_count < H_ACT) && (v_count < V_ACT),
      hsync:       (h_count >= H_SYNC_BEGIN) && (h_count < H_SYNC_END),
      vsync:       (v_count >= V_SYNC_BEGIN) && (v_count < V_SYNC_END),
      frame_start: (h_count == '0) && (v_count == '0)
   };
   assign fetch_0     = flags_0.active && (h_count[1:0] == 2'b00);
   assign buffer_base = displayed_buffer_out ? BUF_B_BASE : '0;

   // The strobe is qualified by enable so a frozen pipeline never repeats a read;
   // data is consumed at the same enabled edge that completes the read.
   assign fb_read_enable_out = read_q && enable_in;

   // Stage 0: raster counters and the per-frame word pointer.
   // NOTE: every clocked block uses non-blocking assignments so all stages
   // sample the previous-cycle values of each other regardless of block order.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         h_count  <= '0;
         v_count  <= '0;
         word_ptr <= '0;
      end else if (enable_in) begin
         if (h_wrap) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + V_W'(1);
         end else begin
            h_count <= h_count + H_W'(1);
         end
         if (frame_wrap) begin
            word_ptr <= '0;
         end else if (fetch_0) begin
            word_ptr <= word_ptr + ADDR_W'(1);
         end
      end
   end

   // Buffer swap: remember a request, apply it only on entry to vertical blank.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         swap_pending         <= 1'b0;
         displayed_buffer_out <= 1'b0;
      end else if (enable_in && vblank_entry) begin
         if (swap_pending) begin
            displayed_buffer_out <= ~displayed_buffer_out;
         end
         swap_pending <= swap_request_in;
      end else if (swap_request_in) begin
         swap_pending <= 1'b1;
      end
   end

   // Stage 1: read request plus the position information the unpacker needs.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         read_q           <= 1'b0;
         fb_read_addr_out <= '0;
         phase_1          <= 2'b00;
         flags_1          <= '0;
      end else if (enable_in) begin
         read_q  <= fetch_0;
         phase_1 <= h_count[1:0];
         flags_1 <= flags_0;
         if (fetch_0) begin
            fb_read_addr_out <= buffer_base + word_ptr;
         end
      end
   end

   // Word holding register for pixels 1..3 of the current word.
   // NOTE: no reset here; it is pure data, always loaded by phase 0 before
   // phases 1..3 of the same word read it.
   always_ff @(posedge clock_in) begin
      if (enable_in && read_q) begin
         word_reg <= fb_read_data_in;
      end
   end

   // Stage 2: unpack the pixel index, VOID outside the active region.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         pixel_index_out <= 4'h0;
         flags_2         <= '0;
      end else if (enable_in) begin
         flags_2 <= flags_1;
         if (!flags_1.active) begin
            pixel_index_out <= 4'h0;
         end else if (read_q) begin
            pixel_index_out <= fb_read_data_in[3:0];
         end else begin
            pixel_index_out <= word_reg[{phase_1, 2'b00} +: 4];
         end
      end
   end

   // Stage 3: flags one cycle behind the index, matching the palette output.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         active_out      <= 1'b0;
         hsync_out       <= 1'b0;
         vsync_out       <= 1'b0;
         frame_start_out <= 1'b0;
      end else if (enable_in) begin
         active_out      <= flags_2.active;
         hsync_out       <= flags_2.hsync;
         vsync_out       <= flags_2.vsync;
         frame_start_out <= flags_2.frame_start;
      end
   end

endmodule

// File: tb/tb_display_pixel_fetcher.sv
// Self-checking bench for display_pixel_fetcher on a reduced raster.
// The reference model tracks only the count of enabled cycles since reset and
// derives every expected output from raster arithmetic on that count.
module tb_display_pixel_fetcher;

   localparam int HA    = 16;
   localparam int VA    = 6;
   localparam int HT    = 24;
   localparam int VT    = 10;
   localparam int HSP   = 18;
   localparam int HSL   = 3;
   localparam int VSP   = 7;
   localparam int VSL   = 2;
   localparam int AW    = 8;
   localparam int FRAME = HT * VT;
   localparam int BUF_B = HA * VA / 4;
   localparam int READS_PER_FRAME = HA / 4 * VA;

   logic          clock_in = 1'b0;
   logic          reset_in = 1'b1;
   logic          enable_in = 1'b0;
   logic          swap_request_in = 1'b0;
   logic          fb_read_enable_out;
   logic [AW-1:0] fb_read_addr_out;
   logic [15:0]   fb_read_data_in;
   logic [3:0]    pixel_index_out;
   logic          active_out;
   logic          hsync_out;
   logic          vsync_out;
   logic          frame_start_out;
   logic          displayed_buffer_out;

   display_pixel_fetcher #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
      .H_SYNC_POS(HSP), .H_SYNC_LEN(HSL), .V_SYNC_POS(VSP), .V_SYNC_LEN(VSL),
      .ADDR_W(AW)
   ) dut (
      .clock_in(clock_in),
      .reset_in(reset_in),
      .enable_in(enable_in),
      .swap_request_in(swap_request_in),
      .fb_read_enable_out(fb_read_enable_out),
      .fb_read_addr_out(fb_read_addr_out),
      .fb_read_data_in(fb_read_data_in),
      .pixel_index_out(pixel_index_out),
      .active_out(active_out),
      .hsync_out(hsync_out),
      .vsync_out(vsync_out),
      .frame_start_out(frame_start_out),
      .displayed_buffer_out(displayed_buffer_out)
   );

   always #5 clock_in = ~clock_in;

   // Frame-buffer model: data valid while the strobe is up, junk otherwise.
   logic [15:0] mem [256];
   logic [15:0] junk = 16'h5A5A;
   always @(posedge clock_in) junk <= 16'($urandom);
   always_comb fb_read_data_in = fb_read_enable_out ? mem[fb_read_addr_out] : junk;

   int n_checks = 0;
   int n_errors = 0;

   int steps = 0;
   bit model_buf = 1'b0;
   bit model_pending = 1'b0;
   bit model_live = 1'b0;
   bit restart_watch = 1'b0;
   int read_count = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, steps);
      end
   endtask

   function automatic int pos_h(int s);
      return (s % FRAME) % HT;
   endfunction

   function automatic int pos_v(int s);
      return (s % FRAME) / HT;
   endfunction

   function automatic bit in_active(int s);
      return pos_h(s) < HA && pos_v(s) < VA;
   endfunction

   function automatic bit fetch_at(int s);
      return in_active(s) && (pos_h(s) % 4 == 0);
   endfunction

   function automatic int buf_base();
      return model_buf ? BUF_B : 0;
   endfunction

   function automatic int word_index(int s);
      return (pos_v(s) * HA + pos_h(s)) / 4;
   endfunction

   function automatic int exp_pixel(int s);
      int w;
      if (!in_active(s)) return 0;
      w = int'(mem[buf_base() + word_index(s)]);
      return (w >> (4 * (pos_h(s) % 4))) & 15;
   endfunction

   function automatic bit at_vblank_entry(int s);
      return pos_h(s) == HT - 1 && pos_v(s) == VA - 1;
   endfunction

   task automatic check_strobe(input logic en);
      logic exp_rd;
      if (!model_live) return;
      exp_rd = en && steps >= 1 && fetch_at(steps - 1);
      check("rd_strobe", 32'(fb_read_enable_out), 32'(exp_rd));
      if (exp_rd) begin
         check("rd_addr", 32'(fb_read_addr_out), 32'(buf_base() + word_index(steps - 1)));
         read_count++;
         if (restart_watch) begin
            check("restart_addr", 32'(fb_read_addr_out), 32'd0);
            restart_watch = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      int q;
      if (!model_live) return;
      check("pixel", 32'(pixel_index_out), 32'(steps >= 2 ? exp_pixel(steps - 2) : 0));
      q = steps - 3;
      check("active", 32'(active_out), 32'(steps >= 3 && in_active(q)));
      check("hsync", 32'(hsync_out),
            32'(steps >= 3 && pos_h(q) >= HSP && pos_h(q) < HSP + HSL));
      check("vsync", 32'(vsync_out),
            32'(steps >= 3 && pos_v(q) >= VSP && pos_v(q) < VSP + VSL));
      check("frame_start", 32'(frame_start_out),
            32'(steps >= 3 && pos_h(q) == 0 && pos_v(q) == 0));
      check("buffer", 32'(displayed_buffer_out), 32'(model_buf));
   endtask

   // One clock: drive inputs, check the strobe, advance the model, check outputs.
   task automatic tick(input logic rst, input logic en, input logic req);
      reset_in        = rst;
      enable_in       = en;
      swap_request_in = req;
      #1 check_strobe(en);
      @(posedge clock_in);
      if (rst) begin
         steps         = 0;
         model_buf     = 1'b0;
         model_pending = 1'b0;
         model_live    = 1'b1;
         read_count    = 0;
      end else begin
         if (en && at_vblank_entry(steps)) begin
            if (model_pending) model_buf = !model_buf;
            model_pending = req;
         end else if (req) begin
            model_pending = 1'b1;
         end
         if (en) steps++;
      end
      @(negedge clock_in);
      check_outputs();
   endtask

   initial begin
      logic [15:0] word0;
      bit          buf_before;
      word0 = 16'hDCBA;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = word0;

      @(negedge clock_in);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);

      // One clean frame: unpack order of word 0 and total read count.
      for (int i = 0; i < FRAME; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (steps >= 2 && steps <= 5)
            check("word0_pixel", 32'(pixel_index_out), 32'(word0[4 * (steps - 2) +: 4]));
      end
      check("reads_per_frame", 32'(read_count), 32'(READS_PER_FRAME));

      // Two swap pulses in one frame give a single swap at vertical blank.
      buf_before = model_buf;
      for (int i = 0; i < FRAME; i++)
         tick(1'b0, 1'b1, (i == 40 || i == 70) ? 1'b1 : 1'b0);
      check("double_pulse_swap", 32'(displayed_buffer_out), 32'(!buf_before));
      for (int i = 0; i < FRAME; i++) tick(1'b0, 1'b1, 1'b0);

      // Pulse exactly on the vertical-blank entry cycle is deferred one frame.
      for (int i = 0; i < FRAME && !at_vblank_entry(steps); i++) tick(1'b0, 1'b1, 1'b0);
      buf_before = model_buf;
      tick(1'b0, 1'b1, 1'b1);
      check("vblank_pulse_deferred", 32'(displayed_buffer_out), 32'(buf_before));
      for (int i = 0; i < FRAME; i++) tick(1'b0, 1'b1, 1'b0);
      check("vblank_pulse_applied", 32'(displayed_buffer_out), 32'(!buf_before));

      // Random enable gaps and occasional swap requests.
      for (int i = 0; i < 8 * FRAME; i++)
         tick(1'b0, ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);

      // Reset in the middle of the active area restarts the scan.
      for (int i = 0; i < FRAME && !(pos_h(steps) == 10 && pos_v(steps) == 3); i++)
         tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      check("reset_pixel", 32'(pixel_index_out), 32'd0);
      check("reset_active", 32'(active_out), 32'd0);
      restart_watch = 1'b1;
      for (int i = 0; i < FRAME + 20; i++)
         tick(1'b0, ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, 1'b0);
      check("restart_seen", 32'(restart_watch), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
